// File: rtl/bit_deglitch_if.sv
// Signal bundle between the deglitch stage and its back-end consumer.
// The master side drives the raw level and controls, and the slave side returns the filtered level, strobes and count.
interface bit_deglitch_if #(
  parameter int CNT_W = 8
);
  logic             in;
  logic             en;
  logic             clr_cnt;
  logic             out;
  logic             outb;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output in, en, clr_cnt,
    input  out, outb, rise, fall, edge_cnt
  );

  modport slave (
    input  in, en, clr_cnt,
    output out, outb, rise, fall, edge_cnt
  );
endinterface

// File: rtl/bit_deglitch.sv
// Synchronizes an asynchronous level into clk and accepts a change only after it has held for NSTABLE cycles.
// The block also produces single-cycle rise/fall strobes and a saturating count of accepted edges.
module bit_deglitch #(
  parameter int NSYNC   = 2,
  parameter int NSTABLE = 4,
  parameter int CNT_W   = 8
) (
  input logic           clk,
  input logic           rstn,
  bit_deglitch_if.slave bus
);
  localparam int               CW      = $clog2(NSTABLE) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(NSTABLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, PEND} state_t;

  logic [NSYNC-1:0] sync;
  logic             s;
  state_t           state;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             out_q, out_nxt;
  logic             rise_q, rise_nxt;
  logic             fall_q, fall_nxt;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_nxt;
  logic             toggle;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
    end else begin
      sync[0] <= bus.in;
      for (int i = 1; i < NSYNC; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign s = sync[NSYNC-1];

  // PEND means the synchronized level disagrees with the accepted one, so a change is being qualified.
  assign state = (s == out_q) ? IDLE : PEND;

  always_comb begin
    cnt_nxt      = '0;
    out_nxt      = out_q;
    rise_nxt     = 1'b0;
    fall_nxt     = 1'b0;
    toggle       = 1'b0;
    edge_cnt_nxt = edge_cnt_q;
    if (bus.en && state == PEND) begin
      if (cnt == LAST) begin
        toggle   = 1'b1;
        out_nxt  = ~out_q;
        rise_nxt = ~out_q;
        fall_nxt = out_q;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
    // A clear wins over a simultaneous toggle, although the toggle and its strobe still happen.
    if (bus.clr_cnt) begin
      edge_cnt_nxt = '0;
    end else if (toggle && edge_cnt_q != CNT_MAX) begin
      edge_cnt_nxt = edge_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      out_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      cnt        <= cnt_nxt;
      out_q      <= out_nxt;
      rise_q     <= rise_nxt;
      fall_q     <= fall_nxt;
      edge_cnt_q <= edge_cnt_nxt;
    end
  end

  assign bus.out      = out_q;
  assign bus.outb     = ~out_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.edge_cnt = edge_cnt_q;
endmodule

// File: tb/tb_bit_deglitch.sv
// Scoreboard bench for bit_deglitch: drives a default instance and a corner instance (NSYNC=1, NSTABLE=1, CNT_W=2) in parallel.
// The reference model accepts a change when the last NSTABLE enabled samples of the delayed input all disagree with out.
module tb_bit_deglitch;
  localparam int NSYNC_P   [2] = '{2, 1};
  localparam int NSTABLE_P [2] = '{4, 1};
  localparam int CMAX_P    [2] = '{255, 3};

  typedef struct {
    bit o0, r0, f0, o1, r1, f1;
    int c0, c1;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic in_drv, en_drv, clr_drv;

  bit_deglitch_if #(.CNT_W(8)) bus_a ();
  bit_deglitch_if #(.CNT_W(2)) bus_b ();

  assign bus_a.in      = in_drv;
  assign bus_a.en      = en_drv;
  assign bus_a.clr_cnt = clr_drv;
  assign bus_b.in      = in_drv;
  assign bus_b.en      = en_drv;
  assign bus_b.clr_cnt = clr_drv;

  bit_deglitch #(.NSYNC(2), .NSTABLE(4), .CNT_W(8)) u_dflt (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a.slave)
  );

  bit_deglitch #(.NSYNC(1), .NSTABLE(1), .CNT_W(2)) u_corner (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b.slave)
  );

  always #5 clk = ~clk;

  int   n_vectors = 0;
  int   n_fail    = 0;
  exp_t sb[$];

  bit in_hist[$];
  bit en_hist[$];
  bit m_out  [2];
  int m_last [2];
  int m_cnt  [2];
  bit m_rise [2];
  bit m_fall [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vectors++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic bit s_at(input int k, input int j);
    return (j >= NSYNC_P[k]) ? in_hist[j - NSYNC_P[k]] : 1'b0;
  endfunction

  task automatic model_reset();
    in_hist.delete();
    en_hist.delete();
    for (int k = 0; k < 2; k++) begin
      m_out[k]  = 1'b0;
      m_last[k] = -1;
      m_cnt[k]  = 0;
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
    end
  endtask

  // One rising edge: a toggle needs NSTABLE enabled, disagreeing samples since the last toggle or reset.
  task automatic model_edge(input bit in_v, input bit en_v, input bit clr_v);
    int e;
    bit tog;
    e = in_hist.size();
    in_hist.push_back(in_v);
    en_hist.push_back(en_v);
    for (int k = 0; k < 2; k++) begin
      tog = (e - m_last[k] >= NSTABLE_P[k]);
      if (tog) begin
        for (int j = e - NSTABLE_P[k] + 1; j <= e; j++) begin
          if (!en_hist[j] || s_at(k, j) == m_out[k]) tog = 1'b0;
        end
      end
      m_rise[k] = tog && !m_out[k];
      m_fall[k] = tog && m_out[k];
      if (tog) begin
        m_out[k]  = ~m_out[k];
        m_last[k] = e;
      end
      if (clr_v) m_cnt[k] = 0;
      else if (tog && m_cnt[k] < CMAX_P[k]) m_cnt[k]++;
    end
  endtask

  task automatic push_expect();
    exp_t x;
    x.o0 = m_out[0];  x.r0 = m_rise[0]; x.f0 = m_fall[0]; x.c0 = m_cnt[0];
    x.o1 = m_out[1];  x.r1 = m_rise[1]; x.f1 = m_fall[1]; x.c1 = m_cnt[1];
    sb.push_back(x);
  endtask

  task automatic applyStimulus(input bit rst_v, input bit in_v, input bit en_v, input bit clr_v);
    @(negedge clk);
    rstn    = rst_v;
    in_drv  = in_v;
    en_drv  = en_v;
    clr_drv = clr_v;
    if (rst_v) model_edge(in_v, en_v, clr_v);
    else model_reset();
    push_expect();
  endtask

  // Drop reset between clock edges and confirm the outputs clear without waiting for a clock.
  task automatic mid_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async.out_a",  32'(bus_a.out),      32'd0);
    checkOutput("async.outb_a", 32'(bus_a.outb),     32'd1);
    checkOutput("async.rise_a", 32'(bus_a.rise),     32'd0);
    checkOutput("async.fall_a", 32'(bus_a.fall),     32'd0);
    checkOutput("async.cnt_a",  32'(bus_a.edge_cnt), 32'd0);
    checkOutput("async.out_b",  32'(bus_b.out),      32'd0);
    checkOutput("async.cnt_b",  32'(bus_b.edge_cnt), 32'd0);
    model_reset();
    push_expect();
  endtask

  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        checkOutput("dflt.out",   32'(bus_a.out),      32'(ex.o0));
        checkOutput("dflt.outb",  32'(bus_a.outb),     32'(!ex.o0));
        checkOutput("dflt.rise",  32'(bus_a.rise),     32'(ex.r0));
        checkOutput("dflt.fall",  32'(bus_a.fall),     32'(ex.f0));
        checkOutput("dflt.cnt",   32'(bus_a.edge_cnt), 32'(ex.c0));
        checkOutput("corner.out", 32'(bus_b.out),      32'(ex.o1));
        checkOutput("corner.outb",32'(bus_b.outb),     32'(!ex.o1));
        checkOutput("corner.rise",32'(bus_b.rise),     32'(ex.r1));
        checkOutput("corner.fall",32'(bus_b.fall),     32'(ex.f1));
        checkOutput("corner.cnt", 32'(bus_b.edge_cnt), 32'(ex.c1));
      end
    end
  end

  initial begin
    int  run_left;
    bit  lvl;
    rstn    = 1'b0;
    in_drv  = 1'b1;
    en_drv  = 1'b1;
    clr_drv = 1'b0;
    model_reset();

    // Reset held with in high, then released: in is accepted as a normal rise.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    // Glitch of 3 cycles is rejected; 4 cycles pulses out.
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    // Enable dropped mid-qualification restarts the count.
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset while a rise is pending; no stale toggle after release.
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    mid_reset();
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    // Clear on the same edge as a toggle.
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    run_left = 0;
    lvl      = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (run_left == 0) begin
        lvl      = ~lvl;
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      applyStimulus(1'b1, lvl, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
    end

    repeat (2) @(negedge clk);
    checkOutput("sb.leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end
endmodule
